// File: rtl/instr_encoder_pkg.sv
// Shared types and helpers for the RV32I field-to-word encoder.
// Inverse of the decoder: fields plus instruction type in, raw word out.
package instr_encoder_pkg;

  typedef logic [6:0]  opcode_t;
  typedef logic [4:0]  regId_t;
  typedef logic [31:0] raw_instr_t;

  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_FENCE  = 7'b0001111;
  localparam opcode_t OPC_OPIMM  = 7'b0010011;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_SYSTEM = 7'b1110011;

  localparam raw_instr_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    instr_type_R,
    instr_type_I,
    instr_type_S,
    instr_type_SB,
    instr_type_U,
    instr_type_UJ,
    instr_type_ILLEGAL
  } instr_type_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    regId_t      rs1;
    regId_t      rs2;
    regId_t      rd;
    logic [31:0] imm;
    instr_type_t itype;
  } decoded_instr_t;

  typedef struct packed {
    logic       err;
    raw_instr_t instr;
  } enc_word_t;

  // Opcode to format; anything unrecognised is reported, not asserted on
  function automatic instr_type_t get_instr_type(input opcode_t op);
    instr_type_t t;
    unique case (op)
      OPC_OP:     t = instr_type_R;
      OPC_LOAD,
      OPC_FENCE,
      OPC_OPIMM,
      OPC_JALR,
      OPC_SYSTEM: t = instr_type_I;
      OPC_STORE:  t = instr_type_S;
      OPC_BRANCH: t = instr_type_SB;
      OPC_LUI,
      OPC_AUIPC:  t = instr_type_U;
      OPC_JAL:    t = instr_type_UJ;
      default:    t = instr_type_ILLEGAL;
    endcase
    return t;
  endfunction

  // Scatter the decoded fields back into their RV32I bit positions
  function automatic raw_instr_t encode_instruction(input decoded_instr_t d);
    raw_instr_t w;
    unique case (d.itype)
      instr_type_R:
        w = {d.funct7, d.rs2, d.rs1, d.funct3, d.rd, d.opcode};
      instr_type_I:
        w = {d.imm[11:0], d.rs1, d.funct3, d.rd, d.opcode};
      instr_type_S:
        w = {d.imm[11:5], d.rs2, d.rs1, d.funct3,
             d.imm[4:0], d.opcode};
      instr_type_SB:
        w = {d.imm[12], d.imm[10:5], d.rs2, d.rs1, d.funct3,
             d.imm[4:1], d.imm[11], d.opcode};
      instr_type_U:
        w = {d.imm[19:0], d.rd, d.opcode};
      instr_type_UJ:
        w = {d.imm[20], d.imm[10:1], d.imm[11], d.imm[19:12],
             d.rd, d.opcode};
      default:
        w = NOP_INSTR;
    endcase
    return w;
  endfunction

  // Unknown opcode, or a branch/jump offset that is not 2-byte aligned
  function automatic logic encode_error(input decoded_instr_t d);
    logic e;
    unique case (d.itype)
      instr_type_ILLEGAL: e = 1'b1;
      instr_type_SB,
      instr_type_UJ:      e = d.imm[0];
      default:            e = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_pipe_reg.sv
// One valid/ready register slot with a synchronous flush.
// Holds its word until the consumer takes it; refills in the same cycle.
module pipe_reg
  import instr_encoder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         load;

  assign load      = !valid_q || out_ready;
  assign in_ready  = load;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Flush wins; otherwise refill when empty or draining
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Slot state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field encoder: S1 captures fields and format, S2 holds the word.
// Output words carry a running address and an unencodable flag.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam int DW = $bits(decoded_instr_t);
  localparam int EW = $bits(enc_word_t);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  decoded_instr_t s1_in;
  decoded_instr_t s1_out;
  enc_word_t      s2_in;
  enc_word_t      s2_out;

  logic s1_in_ready;
  logic s1_valid;
  logic s2_in_ready;

  logic              xfer;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        errcnt_q;
  logic [7:0]        errcnt_d;

  // Capture fields plus the format derived from the opcode
  always_comb begin
    s1_in        = '0;
    s1_in.opcode = in_opcode;
    s1_in.funct3 = in_funct3;
    s1_in.funct7 = in_funct7;
    s1_in.rs1    = in_rs1;
    s1_in.rs2    = in_rs2;
    s1_in.rd     = in_rd;
    s1_in.imm    = in_imm;
    s1_in.itype  = get_instr_type(in_opcode);
  end

  assign in_ready = !clear && s1_in_ready;

  pipe_reg #(.W(DW)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid && !clear),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_out)
  );

  // Pack between stages so S2 is a clean output register
  always_comb begin
    s2_in       = '0;
    s2_in.instr = encode_instruction(s1_out);
    s2_in.err   = encode_error(s1_out);
  end

  pipe_reg #(.W(EW)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out_instr = s2_out.instr;
  assign out_err   = s2_out.err;
  assign out_addr  = addr_q;
  assign err_count = errcnt_q;

  // A flush cancels any output transfer in the same cycle
  assign xfer = out_valid && out_ready && !clear;

  // Word address and saturating error tally
  always_comb begin
    addr_d   = addr_q;
    errcnt_d = errcnt_q;
    if (clear) begin
      addr_d = BASE;
    end else if (xfer) begin
      addr_d = addr_q + 1'b1;
    end
    if (xfer && out_err && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  // Address and error counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= BASE;
      errcnt_q <= 8'd0;
    end else begin
      addr_q   <= addr_d;
      errcnt_q <= errcnt_d;
    end
  end

endmodule
